// File: rtl/counter_pkg.sv
// Shared opcode/state types and default width for the command-driven up/down counter.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_INC       = 3'd1,
        OP_DEC       = 3'd2,
        OP_LOAD      = 3'd3,
        OP_CLEAR     = 3'd4,
        OP_READ      = 3'd5,
        OP_CLR_FLAGS = 3'd6,
        OP_RSVD      = 3'd7
    } cmd_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/counter_if.sv
// Bundle of every counter_core port, with a driver view and a passive monitor view.
interface counter_if #(
    parameter int WIDTH = 4
) (
    input logic clk
);
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport drv_mp (
        input  clk, cmd_ready, count, zero, tc, ovf, unf, rsp_valid, rsp_data,
        output rst_n, cmd_valid, cmd_op, cmd_data, rsp_ready
    );

    modport mon_mp (
        input clk, rst_n, cmd_valid, cmd_ready, cmd_op, cmd_data, count, zero,
              tc, ovf, unf, rsp_valid, rsp_ready, rsp_data
    );
endinterface

// File: rtl/counter_next.sv
// Combinational next-count logic: applies one opcode and reports boundary hits.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [WIDTH-1:0] count_i,
    input  cmd_op_e          op_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             hit_max_o,
    output logic             hit_zero_o
);
    localparam logic [WIDTH-1:0] MAX = '1;

    always_comb begin
        next_count_o = count_i;
        hit_max_o    = 1'b0;
        hit_zero_o   = 1'b0;
        case (op_i)
            OP_INC: begin
                if (count_i == MAX) begin
                    hit_max_o    = 1'b1;
                    next_count_o = SAT_EN ? MAX : '0;
                end else begin
                    next_count_o = count_i + WIDTH'(1);
                end
            end
            OP_DEC: begin
                if (count_i == '0) begin
                    hit_zero_o   = 1'b1;
                    next_count_o = SAT_EN ? '0 : MAX;
                end else begin
                    next_count_o = count_i - WIDTH'(1);
                end
            end
            OP_LOAD:  next_count_o = data_i;
            OP_CLEAR: next_count_o = '0;
            default:  next_count_o = count_i;
        endcase
    end
endmodule

// File: rtl/counter_core.sv
// Up/down counter with valid/ready command intake and a held READ response.
// state | meaning
// IDLE  | accepting commands, cmd_ready = 1
// RESP  | READ response pending on rsp_*, commands stalled
module counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    cmd_op_e          op;
    logic [WIDTH-1:0] next_count;
    logic             hit_max;
    logic             hit_zero;

    assign op = cmd_op_e'(cmd_op);

    counter_next #(
        .WIDTH  (WIDTH),
        .SAT_EN (SAT_EN)
    ) u_next (
        .count_i      (count_q),
        .op_i         (op),
        .data_i       (cmd_data),
        .next_count_o (next_count),
        .hit_max_o    (hit_max),
        .hit_zero_o   (hit_zero)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tc_d        = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    count_d = next_count;
                    tc_d    = hit_max | hit_zero;
                    ovf_d   = ovf_q | hit_max;
                    unf_d   = unf_q | hit_zero;
                    if (op == OP_CLR_FLAGS) begin
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                    if (op == OP_READ) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = count_q;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            tc_q        <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tc_q        <= tc_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign count     = count_q;
    assign zero      = (count_q == '0);
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_counter_core.sv
// Directed bench: a wrapping (bus0) and a saturating (bus1) counter driven with identical commands.
module tb_counter_core;
    import counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    counter_if #(.WIDTH(4)) bus0 (.clk(clk));
    counter_if #(.WIDTH(4)) bus1 (.clk(clk));

    counter_core #(.WIDTH(4), .SAT_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(bus0.rst_n), .cmd_valid(bus0.cmd_valid), .cmd_ready(bus0.cmd_ready),
        .cmd_op(bus0.cmd_op), .cmd_data(bus0.cmd_data), .count(bus0.count), .zero(bus0.zero),
        .tc(bus0.tc), .ovf(bus0.ovf), .unf(bus0.unf), .rsp_valid(bus0.rsp_valid),
        .rsp_ready(bus0.rsp_ready), .rsp_data(bus0.rsp_data)
    );

    counter_core #(.WIDTH(4), .SAT_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(bus1.rst_n), .cmd_valid(bus1.cmd_valid), .cmd_ready(bus1.cmd_ready),
        .cmd_op(bus1.cmd_op), .cmd_data(bus1.cmd_data), .count(bus1.count), .zero(bus1.zero),
        .tc(bus1.tc), .ovf(bus1.ovf), .unf(bus1.unf), .rsp_valid(bus1.rsp_valid),
        .rsp_ready(bus1.rsp_ready), .rsp_data(bus1.rsp_data)
    );

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] d);
        bus0.cmd_valid = v; bus0.cmd_op = op; bus0.cmd_data = d;
        bus1.cmd_valid = v; bus1.cmd_op = op; bus1.cmd_data = d;
    endtask

    task automatic set_rst(input logic r);
        bus0.rst_n = r; bus1.rst_n = r;
    endtask

    task automatic set_rdy(input logic r);
        bus0.rsp_ready = r; bus1.rsp_ready = r;
    endtask

    // One rising edge, then settle to the falling edge for sampling and driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_rst(1'b0); set_rdy(1'b0);
        drive(1'b1, 3'd1, 4'd0);
        cyc(); cyc();
        checks++; if (bus0.count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", bus0.count); end
        checks++; if ({bus0.tc, bus0.ovf, bus0.unf} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {bus0.tc, bus0.ovf, bus0.unf}); end
        checks++; if (bus0.rsp_valid !== 1'b0 || bus0.rsp_data !== 4'd0) begin errors++; $display("FAIL rst_rsp: got v=%b d=%0d exp v=0 d=0", bus0.rsp_valid, bus0.rsp_data); end
        checks++; if (bus0.zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %b exp 1", bus0.zero); end
        set_rst(1'b1);
        drive(1'b0, 3'd0, 4'd0);
        cyc();
        checks++; if (bus0.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", bus0.cmd_ready); end
    endtask

    task automatic test_inc_wrap();
        logic [3:0] exp0, exp1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 3'd1, 4'd0);
            cyc();
            exp0 = 4'(i % 16);
            exp1 = (i >= 15) ? 4'd15 : 4'(i);
            checks++; if (bus0.count !== exp0) begin errors++; $display("FAIL inc_count[%0d]: got %0d exp %0d", i, bus0.count, exp0); end
            checks++; if (bus0.tc !== (i == 16) || bus0.ovf !== (i == 16)) begin errors++; $display("FAIL inc_tc_ovf[%0d]: got tc=%b ovf=%b exp %b", i, bus0.tc, bus0.ovf, i == 16); end
            checks++; if (bus1.count !== exp1) begin errors++; $display("FAIL sat_inc_count[%0d]: got %0d exp %0d", i, bus1.count, exp1); end
        end
        checks++; if (bus0.zero !== 1'b1) begin errors++; $display("FAIL wrap_zero: got %b exp 1", bus0.zero); end
        checks++; if (bus1.tc !== 1'b1 || bus1.ovf !== 1'b1) begin errors++; $display("FAIL sat_inc_tc_ovf: got tc=%b ovf=%b exp 1 1", bus1.tc, bus1.ovf); end
        drive(1'b1, 3'd0, 4'd0);
        cyc();
        checks++; if (bus0.tc !== 1'b0 || bus0.ovf !== 1'b1) begin errors++; $display("FAIL inc_tc_pulse: got tc=%b ovf=%b exp tc=0 ovf=1", bus0.tc, bus0.ovf); end
        checks++; if (bus0.count !== 4'd0) begin errors++; $display("FAIL nop_hold: got %0d exp 0", bus0.count); end
    endtask

    task automatic test_sat_dec();
        drive(1'b1, 3'd6, 4'd0); cyc();
        drive(1'b1, 3'd3, 4'd0); cyc();
        checks++; if (bus1.ovf !== 1'b0 || bus1.unf !== 1'b0 || bus1.count !== 4'd0) begin errors++; $display("FAIL sat_load0: got c=%0d o=%b u=%b exp 0 0 0", bus1.count, bus1.ovf, bus1.unf); end
        drive(1'b1, 3'd2, 4'd0); cyc();
        checks++; if (bus1.count !== 4'd0 || bus1.unf !== 1'b1 || bus1.tc !== 1'b1) begin errors++; $display("FAIL sat_dec: got c=%0d u=%b tc=%b exp 0 1 1", bus1.count, bus1.unf, bus1.tc); end
        checks++; if (bus0.count !== 4'd15 || bus0.unf !== 1'b1 || bus0.tc !== 1'b1) begin errors++; $display("FAIL wrap_dec: got c=%0d u=%b tc=%b exp 15 1 1", bus0.count, bus0.unf, bus0.tc); end
        drive(1'b1, 3'd0, 4'd0); cyc();
        checks++; if (bus1.tc !== 1'b0 || bus1.unf !== 1'b1) begin errors++; $display("FAIL sat_dec_pulse: got tc=%b u=%b exp 0 1", bus1.tc, bus1.unf); end
        drive(1'b1, 3'd6, 4'd0); cyc();
        checks++; if (bus1.unf !== 1'b0 || bus1.count !== 4'd0) begin errors++; $display("FAIL sat_clr_flags: got u=%b c=%0d exp 0 0", bus1.unf, bus1.count); end
        checks++; if (bus0.unf !== 1'b0 || bus0.count !== 4'd15) begin errors++; $display("FAIL wrap_clr_flags: got u=%b c=%0d exp 0 15", bus0.unf, bus0.count); end
    endtask

    task automatic test_read_stall();
        set_rdy(1'b0);
        drive(1'b1, 3'd3, 4'd9); cyc();
        drive(1'b1, 3'd5, 4'd0); cyc();
        checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 4'd9 || bus0.cmd_ready !== 1'b0) begin errors++; $display("FAIL read_accept: got v=%b d=%0d rdy=%b exp 1 9 0", bus0.rsp_valid, bus0.rsp_data, bus0.cmd_ready); end
        drive(1'b1, 3'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 4'd9 || bus0.cmd_ready !== 1'b0 || bus0.count !== 4'd9) begin
                errors++; $display("FAIL read_stall[%0d]: got v=%b d=%0d rdy=%b c=%0d exp 1 9 0 9", i, bus0.rsp_valid, bus0.rsp_data, bus0.cmd_ready, bus0.count);
            end
        end
        drive(1'b0, 3'd0, 4'd0);
        set_rdy(1'b1); cyc();
        checks++; if (bus0.rsp_valid !== 1'b0 || bus0.cmd_ready !== 1'b1 || bus0.count !== 4'd9) begin errors++; $display("FAIL read_release: got v=%b rdy=%b c=%0d exp 0 1 9", bus0.rsp_valid, bus0.cmd_ready, bus0.count); end
        set_rdy(1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd3, 4'd3); cyc();
        drive(1'b1, 3'd1, 4'd0); cyc();
        checks++; if (bus0.count !== 4'd4) begin errors++; $display("FAIL b2b_inc: got %0d exp 4", bus0.count); end
        drive(1'b1, 3'd5, 4'd0); cyc();
        checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 4'd4) begin errors++; $display("FAIL b2b_read: got v=%b d=%0d exp 1 4", bus0.rsp_valid, bus0.rsp_data); end
        drive(1'b0, 3'd0, 4'd0);
        set_rdy(1'b1); cyc();
        checks++; if (bus0.rsp_valid !== 1'b0 || bus0.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_release: got v=%b rdy=%b exp 0 1", bus0.rsp_valid, bus0.cmd_ready); end
        set_rdy(1'b0);
    endtask

    task automatic test_reset_in_resp();
        drive(1'b1, 3'd3, 4'd15); cyc();
        drive(1'b1, 3'd1, 4'd0); cyc();
        drive(1'b1, 3'd3, 4'd12); cyc();
        drive(1'b1, 3'd5, 4'd0); cyc();
        checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 4'd12 || bus0.ovf !== 1'b1) begin errors++; $display("FAIL rresp_pre: got v=%b d=%0d o=%b exp 1 12 1", bus0.rsp_valid, bus0.rsp_data, bus0.ovf); end
        drive(1'b0, 3'd0, 4'd0);
        set_rst(1'b0); cyc();
        checks++; if (bus0.rsp_valid !== 1'b0 || bus0.count !== 4'd0 || bus0.ovf !== 1'b0 || bus0.unf !== 1'b0 || bus0.rsp_data !== 4'd0) begin
            errors++; $display("FAIL rresp_reset: got v=%b c=%0d o=%b u=%b d=%0d exp 0 0 0 0 0", bus0.rsp_valid, bus0.count, bus0.ovf, bus0.unf, bus0.rsp_data);
        end
        set_rst(1'b1); cyc();
        checks++; if (bus0.cmd_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL rresp_release: got rdy=%b v=%b exp 1 0", bus0.cmd_ready, bus0.rsp_valid); end
    endtask

    task automatic test_nop_rsvd();
        drive(1'b1, 3'd3, 4'd0); cyc();
        drive(1'b1, 3'd2, 4'd0); cyc();
        drive(1'b1, 3'd7, 4'd5); cyc();
        checks++; if (bus0.count !== 4'd15 || bus0.unf !== 1'b1 || bus0.ovf !== 1'b0 || bus0.tc !== 1'b0 || bus0.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rsvd_op: got c=%0d u=%b o=%b tc=%b rdy=%b exp 15 1 0 0 1", bus0.count, bus0.unf, bus0.ovf, bus0.tc, bus0.cmd_ready);
        end
        drive(1'b1, 3'd0, 4'd5); cyc();
        checks++; if (bus0.count !== 4'd15 || bus0.unf !== 1'b1 || bus0.tc !== 1'b0 || bus0.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL nop_op: got c=%0d u=%b tc=%b rdy=%b exp 15 1 0 1", bus0.count, bus0.unf, bus0.tc, bus0.cmd_ready);
        end
        checks++; if (bus1.count !== 4'd0 || bus1.unf !== 1'b1 || bus1.tc !== 1'b0) begin errors++; $display("FAIL sat_nop_op: got c=%0d u=%b tc=%b exp 0 1 0", bus1.count, bus1.unf, bus1.tc); end
        drive(1'b0, 3'd0, 4'd0);
    endtask

    initial begin
        drive(1'b0, 3'd0, 4'd0);
        set_rst(1'b0); set_rdy(1'b0);
        @(negedge clk);
        test_reset();
        test_inc_wrap();
        test_sat_dec();
        test_read_stall();
        test_back_to_back();
        test_reset_in_resp();
        test_nop_rsvd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_core.md
# counter_core

Synthesizable up/down counter with a command handshake. It is the design under test that the counter bench drives and monitors. Commands arrive one per accepted cycle over a valid/ready channel. Count value, status flags and read responses come back on a second valid/ready channel, which the bench monitor observes.

## Interface
- WIDTH, 4, counter width in bits (legal range 2..16)
- SAT_EN, 0, 0 = wrap at the boundaries, 1 = saturate at the boundaries

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode (see Operation)
- cmd_data  in  WIDTH  load value, used by LOAD only
- count  out  WIDTH  current counter value, registered
- zero  out  1  combinational, count == 0
- tc  out  1  registered one-cycle terminal-count pulse
- ovf  out  1  sticky overflow flag
- unf  out  1  sticky underflow flag
- rsp_valid  out  1  read response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  WIDTH  count captured by READ

## Operation
- Opcodes:
  - 0 NOP
  - 1 INC
  - 2 DEC
  - 3 LOAD
  - 4 CLEAR
  - 5 READ
  - 6 CLR_FLAGS
  - 7 reserved, executes as NOP
- A command is accepted when cmd_valid && cmd_ready at a rising edge. Its effect is visible on outputs after that edge.
- FSM has two states: IDLE and RESP.
  - IDLE: cmd_ready = 1.
  - Accepting READ in IDLE: rsp_data <= count, rsp_valid <= 1, next state RESP. Count is unchanged.
  - RESP: cmd_ready = 0. rsp_valid and rsp_data are held stable until rsp_ready = 1 at an edge. At that edge rsp_valid <= 0 and next state is IDLE.
  - All other opcodes leave the FSM in IDLE.
- INC:
  - count < MAX (2^WIDTH−1): count + 1.
  - count == MAX: count <= 0 if SAT_EN = 0, otherwise count stays MAX. In both modes ovf <= 1 and tc <= 1.
- DEC:
  - count > 0: count − 1.
  - count == 0: count <= MAX if SAT_EN = 0, otherwise count stays 0. In both modes unf <= 1 and tc <= 1.
- LOAD: count <= cmd_data. Flags are unchanged.
- CLEAR: count <= 0. Flags are unchanged.
- CLR_FLAGS: ovf <= 0, unf <= 0. Count is unchanged.
- tc is high for exactly one cycle after each boundary-hitting INC or DEC. On every other edge it is 0.
- Arithmetic is unsigned, modulo 2^WIDTH. No extra width is carried.

## Timing
- Reset: while rst_n = 0 at an edge, the following take their reset values after that edge. Reset wins over any command in the same cycle.
  - count = 0, tc = 0, ovf = 0, unf = 0
  - rsp_valid = 0, rsp_data = 0
  - state = IDLE, so cmd_ready = 1 after the first edge with rst_n = 1 observed
- Reset in RESP abandons the pending response. rsp_valid drops at that edge.
- Command-to-count latency is 1 cycle. READ-to-rsp_valid latency is 1 cycle.
- Back-to-back commands are accepted every cycle while in IDLE. READ costs at least 2 cycles: the accept cycle, then one or more response cycles.
- A READ issued on the cycle after an INC returns the incremented value.
- rsp_ready is ignored while rsp_valid = 0.
- cmd_* inputs are ignored while cmd_ready = 0. The sender must hold cmd_valid and the command stable until accepted.

## Structure
- Package counter_pkg holds:
  - typedef enum logic [2:0] cmd_op_e, with the 8 opcodes above
  - typedef enum logic state_e {IDLE, RESP}
  - localparam default WIDTH = 4
- One sub-module, counter_next. It is combinational: (count, op, data, SAT_EN) → (next_count, hit_max, hit_zero). All registers stay in counter_core.
- The bench interface counter_if carries every port above. Modports:
  - drv_mp: drives cmd_*, rsp_ready, rst_n
  - mon_mp: all signals as inputs

## Test plan
- Reset, then 16 × INC, SAT_EN = 0 → count steps 1..15 then 0. tc and ovf go high on the edge of the 16th INC; tc stays high for 1 cycle only, ovf stays high.
- SAT_EN = 1: LOAD 0, then DEC → count stays 0, unf = 1, tc pulses once. Then CLR_FLAGS → unf = 0, count = 0.
- LOAD 9, READ with rsp_ready held 0 for 3 cycles → rsp_valid = 1 and rsp_data = 9 held stable, cmd_ready = 0 throughout, an INC presented meanwhile is ignored. Raise rsp_ready → rsp_valid drops, cmd_ready = 1, count still 9.
- INC then READ back-to-back starting from count = 3 → rsp_data = 4 one cycle after READ is accepted.
- LOAD 12, READ, then assert rst_n = 0 while in RESP → next edge: rsp_valid = 0, count = 0, flags = 0; cmd_ready = 1 after reset is released.
- Opcode 7 and NOP with cmd_valid = 1 → count, flags and tc unchanged; cmd_ready stays 1.
